// File: rtl/store_buffer_if.sv
// Store buffer port bundle: enqueue from the data cache, drain to memory, load-forward lookup.
// master = cache/load side driving requests, slave = the store buffer itself.
interface store_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          enq_valid;
  logic [31:0]   enq_addr;
  logic [31:0]   enq_data;
  logic [3:0]    enq_byte_en;
  logic          enq_ready;

  logic          drain_valid;
  logic [31:0]   drain_addr;
  logic [31:0]   drain_data;
  logic [3:0]    drain_byte_en;
  logic          drain_ready;

  logic [31:0]   fwd_addr;
  logic          fwd_hit;
  logic          fwd_partial;
  logic [31:0]   fwd_data;

  logic          full;
  logic          empty;
  logic [CW-1:0] count;

  modport master (
    output enq_valid, enq_addr, enq_data, enq_byte_en, drain_ready, fwd_addr,
    input  enq_ready, drain_valid, drain_addr, drain_data, drain_byte_en,
           fwd_hit, fwd_partial, fwd_data, full, empty, count
  );

  modport slave (
    input  enq_valid, enq_addr, enq_data, enq_byte_en, drain_ready, fwd_addr,
    output enq_ready, drain_valid, drain_addr, drain_data, drain_byte_en,
           fwd_hit, fwd_partial, fwd_data, full, empty, count
  );
endinterface

// File: rtl/store_buffer.sv
// In-order store buffer (circular FIFO) with youngest-match load forwarding.
// Define SB_FORWARD_EN to build the forwarding comparators; otherwise any occupancy stalls loads.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          reset_i,
  store_buffer_if.slave sb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [31:0] addr_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [3:0]  be_q   [DEPTH];

  logic full, empty, enq_fire, ret_fire;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign enq_fire = sb.enq_valid && !full && !reset_i;
  assign ret_fire = sb.drain_ready && !empty && !reset_i;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (ret_fire) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (enq_fire) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + 1'b1;
    end
    if (enq_fire && !ret_fire)      count_d = count_q + 1'b1;
    else if (ret_fire && !enq_fire) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload needs no reset: nothing reads it unless its valid/count says so.
  always_ff @(posedge clk_i) begin
    if (enq_fire) begin
      addr_q[tail_q] <= sb.enq_addr;
      data_q[tail_q] <= sb.enq_data;
      be_q[tail_q]   <= sb.enq_byte_en;
    end
  end

  assign sb.enq_ready     = reset_i || !full;
  assign sb.drain_valid   = !reset_i && !empty;
  assign sb.drain_addr    = sb.drain_valid ? addr_q[head_q] : '0;
  assign sb.drain_data    = sb.drain_valid ? data_q[head_q] : '0;
  assign sb.drain_byte_en = sb.drain_valid ? be_q[head_q]   : '0;
  assign sb.full          = !reset_i && full;
  assign sb.empty         = reset_i || empty;
  assign sb.count         = reset_i ? '0 : count_q;

`ifdef SB_FORWARD_EN
  logic        hit_c, part_c;
  logic [31:0] fdata_c;
  logic        unused_ok;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    logic [PW-1:0] idx;
    hit_c   = 1'b0;
    part_c  = 1'b0;
    fdata_c = '0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && valid_q[idx] &&
          (addr_q[idx][31:2] == sb.fwd_addr[31:2])) begin
        if (be_q[idx] == 4'hF) begin
          hit_c   = 1'b1;
          part_c  = 1'b0;
          fdata_c = data_q[idx];
        end else begin
          hit_c   = 1'b0;
          part_c  = 1'b1;
          fdata_c = '0;
        end
      end
    end
  end

  assign sb.fwd_hit     = !reset_i && hit_c;
  assign sb.fwd_partial = !reset_i && part_c;
  assign sb.fwd_data    = reset_i ? '0 : fdata_c;
  assign unused_ok      = ^sb.fwd_addr[1:0];
`else
  logic unused_ok;

  assign sb.fwd_hit     = 1'b0;
  assign sb.fwd_partial = !reset_i && !empty;
  assign sb.fwd_data    = '0;
  assign unused_ok      = ^{sb.fwd_addr, valid_q};
`endif
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4; number of entries; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enq_valid  input  1  store-hit enqueue request from data cache.
REQ-005 enq_addr / enq_data / enq_byte_en  input  32/32/4  store byte address, aligned data, byte enables.
REQ-006 enq_ready  output  1  entry available (= !full).
REQ-007 drain_valid  output  1  head entry presented to cache/memory.
REQ-008 drain_addr / drain_data / drain_byte_en  output  32/32/4  head entry contents.
REQ-009 drain_ready  input  1  cache idle, memory port free; head may retire this cycle.
REQ-010 fwd_addr  input  32  load byte address for forwarding lookup.
REQ-011 fwd_hit / fwd_partial  output  1/1  full-word forward available / partial overlap, load must stall.
REQ-012 fwd_data  output  32  forwarded word.
REQ-013 full / empty  output  1/1  occupancy flags.
REQ-014 count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-015 Circular FIFO: head pointer, tail pointer, count register; pointers wrap modulo DEPTH.
REQ-016 Enqueue fires when enq_valid && !full; the entry is written at tail and tail advances.
REQ-017 enq_valid while full: request dropped, state unchanged; enq_ready = !full uses current-cycle state only, ignoring a same-cycle drain.
REQ-018 drain_valid = !empty; drain_* = head entry, combinational from registers; a just-enqueued entry appears on drain no earlier than the next cycle.
REQ-019 Retire fires when drain_valid && drain_ready; head advances; drain_* held stable while drain_ready is low.
REQ-020 Enqueue and retire in the same cycle: count unchanged, both pointers advance; legal at any occupancy except full, where only the retire occurs.
REQ-021 count: +1 on enqueue only, -1 on retire only, unchanged otherwise; full = (count==DEPTH); empty = (count==0).
REQ-022 Forward lookup compares fwd_addr[31:2] with addr[31:2] of every valid entry, including the head being retired this cycle; same-cycle enqueue is not searched.
REQ-023 The youngest matching entry is selected by age order from tail-1 back to head.
REQ-024 Youngest match with byte_en==4'b1111: fwd_hit=1, fwd_partial=0, fwd_data = that entry's data.
REQ-025 Youngest match with byte_en!=4'b1111: fwd_hit=0, fwd_partial=1, fwd_data=0.
REQ-026 No match: fwd_hit=0, fwd_partial=0, fwd_data=0.
REQ-027 Entry order is strictly preserved; no merging or coalescing.

Reset
REQ-028 On reset the block SHALL clear head, tail and count and all entry valid bits; pending entries are discarded.
REQ-029 Reset asserted with enq_valid or drain_ready high: no enqueue or retire occurs that cycle.
REQ-030 Outputs during and after reset: enq_ready=1, drain_valid=0, drain_*=0, fwd_hit=0, fwd_partial=0, fwd_data=0, full=0, empty=1, count=0.

Configuration
REQ-031 Macro SB_FORWARD_EN defined: the forwarding logic of REQ-022..REQ-026 is compiled in.
REQ-032 SB_FORWARD_EN undefined: no comparators; fwd_hit=0, fwd_data=0, fwd_partial = !empty, so every load stalls until the buffer drains.

Verification
REQ-033 Reset, then enqueue A=0x100/0xAABBCCDD/4'hF with drain_ready=0 -> next cycle count=1, drain_valid=1, drain_addr=0x100, drain_data=0xAABBCCDD.
REQ-034 DEPTH=4: enqueue 5 stores back-to-back with drain_ready=0 -> full=1 after the 4th; the 5th is dropped (enq_ready=0); draining yields the first 4 in order.
REQ-035 Enqueue 0x200/0x11111111/F, then 0x200/0x22222222/F; fwd_addr=0x202 -> fwd_hit=1, fwd_data=0x22222222 (youngest wins).
REQ-036 Enqueue 0x300/0x000000FF/4'h1; fwd_addr=0x300 -> fwd_partial=1, fwd_hit=0; fwd_addr=0x304 -> both 0.
REQ-037 Count=4, drain_ready=1 and enq_valid=1 in the same cycle -> only the retire occurs, count=3; next cycle enqueue plus retire -> count stays 3, tail wraps to 0.
REQ-038 Count=2, assert reset for one cycle with enq_valid=1 -> count=0, empty=1, drain_valid=0 the following cycle.
